stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter SEC_MAX, default 8'h59: BCD terminal value of the seconds counter, driven on sec_rst_val.
REQ-002 Parameter MIN_MAX, default 8'h59: BCD terminal value of the minutes counter, driven on min_rst_val.
REQ-003 clk  input  1  global clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 tick  input  1  one-cycle 1 Hz time-base pulse.
REQ-006 start_stop  input  1  one-cycle button pulse.
REQ-007 clear  input  1  one-cycle button pulse.
REQ-008 mode  input  1  one-cycle button pulse; enters and steps through set mode.
REQ-009 inc  input  1  one-cycle button pulse; bumps the digit pair being set.
REQ-010 lap  input  1  one-cycle button pulse; freezes or unfreezes the display.
REQ-011 limit  input  16  BCD {min,sec} target value.
REQ-012 sec_cnt, min_cnt  input  8 each  current BCD values fed back from the two counters.
REQ-013 sec_inc, min_inc  output  1 each  increase enables to the two counters.
REQ-014 cnt_clr  output  1  one-cycle load-zero command to both counters.
REQ-015 sec_rst_val, min_rst_val  output  8 each  constant SEC_MAX and MIN_MAX.
REQ-016 disp  output  16  BCD {min,sec} value to display.
REQ-017 state  output  3  current FSM state encoding.
REQ-018 done  output  1  high while in state DONE.

Function
REQ-019 FSM states: IDLE=0, RUN=1, PAUSE=2, SET_MIN=3, SET_SEC=4, DONE=5.
REQ-020 FSM transitions:
- IDLE --start_stop--> RUN
- RUN --start_stop--> PAUSE
- PAUSE --start_stop--> RUN
- IDLE or PAUSE --mode--> SET_MIN
- SET_MIN --mode--> SET_SEC
- SET_SEC --mode--> IDLE
- RUN --terminal detect (REQ-024)--> DONE
- DONE --start_stop or clear--> IDLE
- Any other input combination leaves the state unchanged.
REQ-021 Priority when several inputs pulse in the same cycle: clear > start_stop > mode > inc > lap; only the highest-priority pulse takes effect, and the others are dropped.
REQ-022 clear in any state: cnt_clr=1 for exactly one cycle, next state IDLE, lap freeze released.
REQ-023 In RUN, tick is registered so that sec_inc=1 in the cycle after tick. In all other states a tick produces no sec_inc.
REQ-024 min_inc = sec_inc AND (sec_cnt==SEC_MAX), combinational, so the minutes counter advances on the same edge on which seconds wrap to 00.
REQ-025 Terminal detect: in RUN, when {min_cnt,sec_cnt}==limit and sec_inc=0, the next state is DONE. No further sec_inc is issued once limit is reached.
REQ-026 A tick that arrives in the same cycle as the transition to DONE is dropped.
REQ-027 In SET_MIN, inc produces min_inc=1 for one cycle (registered, one cycle after inc); the counter wraps MIN_MAX to 00 itself.
REQ-028 In SET_SEC, inc produces sec_inc=1 for one cycle (registered, one cycle after inc); min_inc stays 0 even when seconds wrap.
REQ-029 sec_inc and min_inc are never high for more than one consecutive cycle per request.
REQ-030 disp defaults to {min_cnt,sec_cnt}, registered with one cycle latency.
REQ-031 In RUN, lap toggles a freeze flag. While frozen, disp holds its last value and counting continues.
REQ-032 Leaving RUN for any state releases the freeze.
REQ-033 lap in any state other than RUN is ignored.
REQ-034 limit==16'h0000 with counters at 00:00 and start_stop from IDLE gives RUN for one cycle, then DONE.
REQ-035 A limit digit that is not valid BCD (nibble > 9) never matches, so the block counts until clear.

Reset
REQ-036 While rst=0: state=IDLE, sec_inc=0, min_inc=0, cnt_clr=0, disp=16'h0000, done=0, freeze=0, registered tick/inc pipeline cleared.
REQ-037 Asserting rst mid-RUN drops any pending sec_inc immediately.
REQ-038 After rst returns high, the first active clock edge evaluates inputs normally.

Verification
REQ-039 Reset, then start_stop, then 3 ticks -> exactly 3 single-cycle sec_inc pulses, each 1 cycle after its tick; state=1.
REQ-040 sec_cnt=8'h59, min_cnt=8'h02, tick in RUN -> sec_inc and min_inc high in the same cycle.
REQ-041 limit=16'h0105, counters reach 01:05 -> state=5, done=1, following ticks give no sec_inc; start_stop -> state=0.
REQ-042 In PAUSE: mode, then inc x2 -> 2 min_inc pulses; mode, then inc -> 1 sec_inc and min_inc=0; mode -> state=0.
REQ-043 RUN, lap at 00:10, 5 ticks -> disp stays 16'h0010 while counters reach 00:15; start_stop -> disp follows counters again.
REQ-044 clear and start_stop in the same cycle during RUN -> cnt_clr one cycle, state=0; rst pulsed low mid-RUN right after a tick -> no sec_inc, all outputs at reset values.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Bundle of button, time-base, limit and counter signals shared by the
// stopwatch controller and whatever drives it.
interface stopwatch_ctrl_if;
  logic        tick;
  logic        start_stop;
  logic        clear;
  logic        mode;
  logic        inc;
  logic        lap;
  logic [15:0] limit;
  logic [7:0]  sec_cnt;
  logic [7:0]  min_cnt;
  logic        sec_inc;
  logic        min_inc;
  logic        cnt_clr;
  logic [7:0]  sec_rst_val;
  logic [7:0]  min_rst_val;
  logic [15:0] disp;
  logic [2:0]  state;
  logic        done;

  // Driver side: buttons, time base, limit and counter feedback.
  modport master (
    output tick, start_stop, clear, mode, inc, lap, limit, sec_cnt, min_cnt,
    input  sec_inc, min_inc, cnt_clr, sec_rst_val, min_rst_val, disp, state, done
  );

  // Controller side.
  modport slave (
    input  tick, start_stop, clear, mode, inc, lap, limit, sec_cnt, min_cnt,
    output sec_inc, min_inc, cnt_clr, sec_rst_val, min_rst_val, disp, state, done
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause/set/done sequencing, increment enables for
// external BCD seconds/minutes counters, limit detection and lap freeze.
module stopwatch_ctrl #(
  parameter logic [7:0] SEC_MAX = 8'h59,
  parameter logic [7:0] MIN_MAX = 8'h59
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PAUSE   = 3'd2,
    S_SET_MIN = 3'd3,
    S_SET_SEC = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sec_run_q, sec_run_d;   // seconds step from a tick in RUN
  logic        sec_set_q, sec_set_d;   // seconds step from inc in SET_SEC
  logic        min_set_q, min_set_d;   // minutes step from inc in SET_MIN
  logic        cnt_clr_q, cnt_clr_d;
  logic        freeze_q, freeze_d;
  logic        done_q;
  logic [15:0] disp_q;
  logic        match;

  // A limit with any non-BCD nibble can never equal a real count.
  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
           (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  assign match = bcd_valid(bus.limit) && ({bus.min_cnt, bus.sec_cnt} == bus.limit);

  // Next-state decode; clear outranks everything, then each state honours
  // start_stop > mode > inc > lap.
  always_comb begin
    state_d   = state_q;
    sec_set_d = 1'b0;
    min_set_d = 1'b0;
    cnt_clr_d = 1'b0;
    freeze_d  = freeze_q;
    // Ticks are taken only in RUN and never once the limit is showing, so
    // the tick that coincides with the move to DONE is dropped.
    sec_run_d = (state_q == S_RUN) && bus.tick && !match && !bus.clear;
    if (bus.clear) begin
      cnt_clr_d = 1'b1;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_stop)  state_d = S_RUN;
          else if (bus.mode)   state_d = S_SET_MIN;
        end
        S_RUN: begin
          if (match && !sec_run_q)  state_d = S_DONE;
          else if (bus.start_stop)  state_d = S_PAUSE;
          else if (!bus.mode && !bus.inc && bus.lap) freeze_d = !freeze_q;
        end
        S_PAUSE: begin
          if (bus.start_stop)  state_d = S_RUN;
          else if (bus.mode)   state_d = S_SET_MIN;
        end
        S_SET_MIN: begin
          if (bus.mode)        state_d = S_SET_SEC;
          else if (bus.inc)    min_set_d = 1'b1;
        end
        S_SET_SEC: begin
          if (bus.mode)        state_d = S_IDLE;
          else if (bus.inc)    sec_set_d = 1'b1;
        end
        S_DONE: begin
          if (bus.start_stop)  state_d = S_IDLE;
        end
        default:               state_d = S_IDLE;
      endcase
    end
    if (state_d != S_RUN) freeze_d = 1'b0;
  end

  // State and registered outputs; reset also drops any pending increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sec_run_q <= 1'b0;
      sec_set_q <= 1'b0;
      min_set_q <= 1'b0;
      cnt_clr_q <= 1'b0;
      freeze_q  <= 1'b0;
      done_q    <= 1'b0;
      disp_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      sec_run_q <= sec_run_d;
      sec_set_q <= sec_set_d;
      min_set_q <= min_set_d;
      cnt_clr_q <= cnt_clr_d;
      freeze_q  <= freeze_d;
      done_q    <= (state_d == S_DONE);
      if (!freeze_q) disp_q <= {bus.min_cnt, bus.sec_cnt};
    end
  end

  // Minutes follow a seconds wrap on the same edge, but only when counting.
  assign bus.sec_inc     = sec_run_q | sec_set_q;
  assign bus.min_inc     = (sec_run_q && (bus.sec_cnt == SEC_MAX)) | min_set_q;
  assign bus.cnt_clr     = cnt_clr_q;
  assign bus.sec_rst_val = SEC_MAX;
  assign bus.min_rst_val = MIN_MAX;
  assign bus.disp        = disp_q;
  assign bus.state       = state_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a BCD seconds/minutes counter pair
// modelled around it.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       ld_en = 1'b0;
  logic [7:0] ld_min = 8'h00;
  logic [7:0] ld_sec = 8'h00;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(.SEC_MAX(8'h59), .MIN_MAX(8'h59)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] mx);
    if (v == mx)          return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return v + 8'h01;
  endfunction

  // External BCD counters driven by the controller's enables.
  always @(posedge clk) begin
    if (ld_en) begin
      bus.sec_cnt <= ld_sec;
      bus.min_cnt <= ld_min;
    end else if (bus.cnt_clr) begin
      bus.sec_cnt <= 8'h00;
      bus.min_cnt <= 8'h00;
    end else begin
      if (bus.sec_inc) bus.sec_cnt <= bcd_step(bus.sec_cnt, 8'h59);
      if (bus.min_inc) bus.min_cnt <= bcd_step(bus.min_cnt, 8'h59);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // b = {tick, start_stop, clear, mode, inc, lap}, held for one cycle.
  task automatic press(input logic [5:0] b);
    {bus.tick, bus.start_stop, bus.clear, bus.mode, bus.inc, bus.lap} = b;
    cyc();
    {bus.tick, bus.start_stop, bus.clear, bus.mode, bus.inc, bus.lap} = 6'b0;
  endtask

  task automatic load(input logic [7:0] m, input logic [7:0] s);
    ld_min = m; ld_sec = s; ld_en = 1'b1;
    cyc();
    ld_en = 1'b0;
  endtask

  localparam logic [5:0] P_TICK = 6'b100000;
  localparam logic [5:0] P_SS   = 6'b010000;
  localparam logic [5:0] P_CLR  = 6'b001000;
  localparam logic [5:0] P_MODE = 6'b000100;
  localparam logic [5:0] P_INC  = 6'b000010;
  localparam logic [5:0] P_LAP  = 6'b000001;

  initial begin
    {bus.tick, bus.start_stop, bus.clear, bus.mode, bus.inc, bus.lap} = 6'b0;
    bus.limit = 16'hFFFF;
    ld_en = 1'b1;
    cyc(); cyc();
    ld_en = 1'b0;
    // Reset values
    check("rst_state", bus.state, 3'd0);
    check("rst_sec_inc", bus.sec_inc, 1'b0);
    check("rst_min_inc", bus.min_inc, 1'b0);
    check("rst_cnt_clr", bus.cnt_clr, 1'b0);
    check("rst_disp", bus.disp, 16'h0000);
    check("rst_done", bus.done, 1'b0);
    check("sec_rst_val", bus.sec_rst_val, 8'h59);
    check("min_rst_val", bus.min_rst_val, 8'h59);
    rst = 1'b1;
    cyc();

    // Start and three ticks
    press(P_SS);
    check("run_state", bus.state, 3'd1);
    for (int i = 0; i < 3; i++) begin
      check("tick_idle_sec_inc", bus.sec_inc, 1'b0);
      press(P_TICK);
      check("tick_sec_inc", bus.sec_inc, 1'b1);
      cyc();
      check("tick_sec_inc_one", bus.sec_inc, 1'b0);
    end
    cyc();
    check("disp_0003", bus.disp, 16'h0003);

    // Seconds wrap carries into minutes
    load(8'h02, 8'h59);
    press(P_TICK);
    check("wrap_sec_inc", bus.sec_inc, 1'b1);
    check("wrap_min_inc", bus.min_inc, 1'b1);
    cyc();
    check("wrap_min_inc_one", bus.min_inc, 1'b0);
    cyc();
    check("disp_0300", bus.disp, 16'h0300);

    // Lap freeze while counting
    load(8'h00, 8'h10);
    cyc();
    press(P_LAP);
    for (int i = 0; i < 5; i++) begin
      press(P_TICK);
      cyc();
    end
    check("lap_disp_frozen", bus.disp, 16'h0010);
    press(P_SS);
    check("pause_state", bus.state, 3'd2);
    cyc();
    check("lap_release_disp", bus.disp, 16'h0015);

    // Set mode from PAUSE
    press(P_MODE);
    check("set_min_state", bus.state, 3'd3);
    for (int i = 0; i < 2; i++) begin
      press(P_INC);
      check("set_min_inc", bus.min_inc, 1'b1);
      check("set_min_no_sec", bus.sec_inc, 1'b0);
      cyc();
      check("set_min_inc_one", bus.min_inc, 1'b0);
    end
    press(P_MODE);
    check("set_sec_state", bus.state, 3'd4);
    press(P_INC);
    check("set_sec_inc", bus.sec_inc, 1'b1);
    check("set_sec_no_min", bus.min_inc, 1'b0);
    press(P_MODE);
    check("set_exit_state", bus.state, 3'd0);
    cyc();
    check("set_disp", bus.disp, 16'h0216);

    // Seconds wrap in SET_SEC leaves minutes alone; mode beats inc
    load(8'h00, 8'h59);
    press(P_MODE | P_INC);
    check("prio_mode_state", bus.state, 3'd3);
    check("prio_mode_no_inc", bus.min_inc, 1'b0);
    press(P_MODE);
    press(P_INC);
    check("setsec_wrap_sec", bus.sec_inc, 1'b1);
    check("setsec_wrap_min", bus.min_inc, 1'b0);
    press(P_MODE);
    check("setsec_exit", bus.state, 3'd0);

    // Limit reached
    bus.limit = 16'h0105;
    load(8'h01, 8'h03);
    press(P_SS);
    press(P_TICK); cyc();
    press(P_TICK); cyc();
    check("limit_pre_state", bus.state, 3'd1);
    press(P_TICK);
    check("done_state", bus.state, 3'd5);
    check("done_flag", bus.done, 1'b1);
    check("done_tick_dropped", bus.sec_inc, 1'b0);
    press(P_TICK);
    check("done_no_sec_inc", bus.sec_inc, 1'b0);
    press(P_SS);
    check("done_exit_state", bus.state, 3'd0);
    check("done_exit_flag", bus.done, 1'b0);

    // Zero limit from cleared counters
    bus.limit = 16'h0000;
    press(P_CLR);
    check("clr_pulse", bus.cnt_clr, 1'b1);
    cyc();
    check("clr_one_cycle", bus.cnt_clr, 1'b0);
    press(P_SS);
    check("zero_run", bus.state, 3'd1);
    cyc();
    check("zero_done", bus.state, 3'd5);
    press(P_CLR);
    check("zero_clr_idle", bus.state, 3'd0);

    // Clear beats start_stop; async reset mid-RUN
    bus.limit = 16'hFFFF;
    press(P_SS);
    press(P_CLR | P_SS);
    check("clr_ss_pulse", bus.cnt_clr, 1'b1);
    check("clr_ss_state", bus.state, 3'd0);
    cyc();
    check("clr_ss_one", bus.cnt_clr, 1'b0);
    check("clr_ss_idle", bus.state, 3'd0);
    press(P_SS);
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_sec_inc", bus.sec_inc, 1'b0);
    check("arst_min_inc", bus.min_inc, 1'b0);
    check("arst_state", bus.state, 3'd0);
    check("arst_disp", bus.disp, 16'h0000);
    check("arst_done", bus.done, 1'b0);
    check("arst_cnt_clr", bus.cnt_clr, 1'b0);
    cyc();
    rst = 1'b1;
    press(P_SS);
    check("post_rst_run", bus.state, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
